// File: rtl/corescore_reset_sequencer.sv
// corescore_reset_sequencer: staged reset release after a stable PLL lock, with a lock-loss counter
//   i_clk            generated system clock (single domain)
//   i_rst_n          synchronous active-low reset
//   i_locked         PLL lock flag, asynchronous to i_clk
//   o_rst            active-high stage resets, bit 0 released first
//   o_ready          high once every stage is released (RUN)
//   o_lock_loss_cnt  saturating count of lock losses seen after WAIT_LOCK
//   o_state          0 WAIT_LOCK, 1 STABLE, 2 RELEASE, 3 RUN
module corescore_reset_sequencer #(
    parameter int STAGES        = 3,
    parameter int STABLE_CYCLES = 1024,
    parameter int GAP_CYCLES    = 16,
    parameter int CNT_W         = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_locked,
    output logic [STAGES-1:0] o_rst,
    output logic              o_ready,
    output logic [CNT_W-1:0]  o_lock_loss_cnt,
    output logic [2:0]        o_state
);
    localparam int SW = $clog2(STABLE_CYCLES);
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    localparam int IW = $clog2(STAGES + 1);
    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3
    } state_t;
    state_t            state, state_d;
    logic              sync1, s_locked;
    logic [SW-1:0]     stab_cnt, stab_d;
    logic [GW-1:0]     gap_cnt, gap_d;
    logic [IW-1:0]     idx, idx_d;
    logic [STAGES-1:0] rst_q, rst_d;
    logic [CNT_W-1:0]  loss_cnt, loss_d;
    always_comb begin
        state_d = state;
        stab_d  = stab_cnt;
        gap_d   = gap_cnt;
        idx_d   = idx;
        rst_d   = rst_q;
        loss_d  = loss_cnt;
        // lock loss outranks any release due on the same edge
        if (state != WAIT_LOCK && !s_locked) begin
            state_d = WAIT_LOCK;
            stab_d  = '0;
            gap_d   = '0;
            idx_d   = '0;
            rst_d   = '1;
            loss_d  = &loss_cnt ? loss_cnt : loss_cnt + 1'b1;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    rst_d = '1;
                    if (s_locked) begin
                        state_d = STABLE;
                        stab_d  = '0;
                    end
                end
                STABLE: begin
                    if (stab_cnt == SW'(STABLE_CYCLES - 1)) begin
                        state_d  = RELEASE;
                        rst_d[0] = 1'b0;
                        gap_d    = '0;
                        idx_d    = IW'(1);
                    end else begin
                        stab_d = stab_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (idx == IW'(STAGES)) begin
                        state_d = RUN;
                    end else if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        for (int i = 0; i < STAGES; i++)
                            if (IW'(i) == idx) rst_d[i] = 1'b0;
                        idx_d = idx + 1'b1;
                        gap_d = '0;
                    end else begin
                        gap_d = gap_cnt + 1'b1;
                    end
                end
                RUN:     rst_d = '0;
                default: state_d = WAIT_LOCK;
            endcase
        end
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync1    <= 1'b0;
            s_locked <= 1'b0;
            state    <= WAIT_LOCK;
            stab_cnt <= '0;
            gap_cnt  <= '0;
            idx      <= '0;
            rst_q    <= '1;
            loss_cnt <= '0;
        end else begin
            sync1    <= i_locked;
            s_locked <= sync1;
            state    <= state_d;
            stab_cnt <= stab_d;
            gap_cnt  <= gap_d;
            idx      <= idx_d;
            rst_q    <= rst_d;
            loss_cnt <= loss_d;
        end
    end
    assign o_rst           = rst_q;
    assign o_ready         = state == RUN;
    assign o_lock_loss_cnt = loss_cnt;
    assign o_state         = state;
endmodule

// File: tb/tb_corescore_reset_sequencer.sv
// tb_corescore_reset_sequencer: randomized and directed checks against an elapsed-lock-time model
module tb_corescore_reset_sequencer;
    localparam int ST = 3, SC = 8, GC = 4, CW = 8;
    localparam int LOSS_MAX = (1 << CW) - 1;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          locked = 1'b0;
    logic [ST-1:0] rst;
    logic          ready;
    logic [CW-1:0] cnt;
    logic [2:0]    state;
    int checks = 0, errors = 0;
    int m_n = 0, m_loss = 0;
    bit m_s1 = 0, m_sl = 0;
    string phase = "init";
    always #5 clk = ~clk;
    corescore_reset_sequencer #(
        .STAGES(ST), .STABLE_CYCLES(SC), .GAP_CYCLES(GC), .CNT_W(CW)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_locked(locked),
        .o_rst(rst),
        .o_ready(ready),
        .o_lock_loss_cnt(cnt),
        .o_state(state)
    );
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s/%s got=%0h exp=%0h", phase, tag, got, exp);
        end
    endtask
    // m_n counts FSM edges seen with synced lock high since leaving WAIT_LOCK
    function automatic logic [ST-1:0] e_rst();
        logic [ST-1:0] e;
        for (int k = 0; k < ST; k++) e[k] = !(m_n >= SC + 1 + k * GC);
        return e;
    endfunction
    function automatic logic [2:0] e_state();
        if (m_n == 0) return 3'd0;
        if (m_n < SC + 1) return 3'd1;
        if (m_n < SC + 2 + (ST - 1) * GC) return 3'd2;
        return 3'd3;
    endfunction
    task automatic cycle(bit r, bit l);
        rst_n  = r;
        locked = l;
        @(posedge clk);
        if (!r) begin
            m_n = 0; m_s1 = 0; m_sl = 0; m_loss = 0;
        end else begin
            if (m_sl) m_n = m_n < 100000 ? m_n + 1 : m_n;
            else begin
                if (m_n > 0 && m_loss < LOSS_MAX) m_loss++;
                m_n = 0;
            end
            m_sl = m_s1;
            m_s1 = l;
        end
        #1;
        check("rst", rst, e_rst());
        check("ready", ready, e_state() == 3'd3);
        check("state", state, e_state());
        check("cnt", cnt, m_loss);
    endtask
    initial begin
        phase = "reset";
        repeat (3) cycle(0, 0);
        check("rst_reset", rst, 3'b111);
        phase = "nolock";
        repeat (50) cycle(1, 0);
        phase = "lockup";
        repeat (25) cycle(1, 1);
        check("run_state", state, 3'd3);
        phase = "runloss";
        cycle(1, 0);
        repeat (2) cycle(1, 1);
        check("loss_rst", rst, 3'b111);
        check("loss_cnt", cnt, 1);
        repeat (25) cycle(1, 1);
        phase = "relloss";
        cycle(0, 0);
        repeat (12) cycle(1, 1);
        check("rel_rst", rst, 3'b110);
        repeat (3) cycle(1, 0);
        check("rel_rst2", rst, 3'b111);
        check("rel_cnt", cnt, 1);
        repeat (10) cycle(1, 0);
        phase = "saturate";
        for (int p = 0; p < 300; p++) begin
            repeat (22) cycle(1, 1);
            cycle(1, 0);
        end
        repeat (3) cycle(1, 0);
        check("sat_cnt", cnt, LOSS_MAX);
        phase = "rstrel";
        cycle(0, 0);
        begin
            int guard = 0;
            while (m_n != SC + GC && guard < 100) begin
                cycle(1, 1);
                guard++;
            end
            check("rstrel_reach", guard < 100, 1);
        end
        check("rstrel_pre", rst, 3'b110);
        cycle(0, 1);
        check("rstrel_rst", rst, 3'b111);
        check("rstrel_state", state, 3'd0);
        check("rstrel_cnt", cnt, 0);
        phase = "random";
        begin
            bit l = 1;
            for (int b = 0; b < 150; b++) begin
                int len = l ? $urandom_range(1, 30) : $urandom_range(1, 4);
                for (int i = 0; i < len; i++) cycle($urandom_range(0, 199) != 0, l);
                l = !l;
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
